// File: rtl/riv_sync_debounce_if.sv
// Interface bundle for riv_sync_debounce. It carries the synchronised input, the
// glitch-counter clear, and the debounced level, edge pulses and status outputs.
interface riv_sync_debounce_if #(
  parameter int unsigned GLITCH_W = 8
);
  logic                sync_in;
  logic                glitch_clr;
  logic                level_out;
  logic                rise_pulse;
  logic                fall_pulse;
  logic                qualifying;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output sync_in, glitch_clr,
    input  level_out, rise_pulse, fall_pulse, qualifying, glitch_cnt
  );

  modport slave (
    input  sync_in, glitch_clr,
    output level_out, rise_pulse, fall_pulse, qualifying, glitch_cnt
  );
endinterface

// File: rtl/riv_sync_debounce.sv
// Debounce qualifier that sits after a 2-FF synchroniser. A new level is accepted
// only after STABLE_CYCLES identical samples; aborted attempts are counted as glitches.
//
//   state     | meaning
//   ST_STABLE | sync_in agrees with level_out, or a STABLE_CYCLES==1 flip just happened
//   ST_QUAL   | a candidate level is being timed; cnt holds the differing samples seen
module riv_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned GLITCH_W      = 8
) (
  input logic                dst_clk,
  input logic                dst_rst_n,
  riv_sync_debounce_if.slave bus
);
  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_QUAL   = 1'b1;

  logic [0:0]          state;
  logic [CW-1:0]       cnt;
  logic                level_q;
  logic                rise_q;
  logic                fall_q;
  logic                qual_q;
  logic [GLITCH_W-1:0] glitch_q;
  logic                differ;
  logic                abort;

  assign differ = (bus.sync_in != level_q);
  assign abort  = (state == ST_QUAL) && !differ;

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      qual_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (differ) begin
            if (STABLE_CYCLES == 1) begin
              level_q <= bus.sync_in;
              rise_q  <= bus.sync_in;
              fall_q  <= !bus.sync_in;
            end else begin
              state  <= ST_QUAL;
              cnt    <= CW'(1);
              qual_q <= 1'b1;
            end
          end
        end
        default: begin
          if (!differ) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            qual_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            level_q <= bus.sync_in;
            rise_q  <= bus.sync_in;
            fall_q  <= !bus.sync_in;
            state   <= ST_STABLE;
            cnt     <= '0;
            qual_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // A clear wins over a same-cycle abort; the counter saturates instead of wrapping.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      glitch_q <= '0;
    end else if (bus.glitch_clr) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.qualifying = qual_q;
  assign bus.glitch_cnt = glitch_q;
endmodule

// File: doc/riv_sync_debounce.md
Name: riv_sync_debounce

Overview:
- Destination-domain qualifier that sits directly downstream of a 2-FF synchroniser output.
- Accepts an already-synchronised level and declares a new level only after it has been sampled unchanged for STABLE_CYCLES consecutive cycles.
- Emits single-cycle rise/fall pulses and a filtered level.
- Keeps a saturating count of rejected glitches for status/debug registers.

Parameters:
- STABLE_CYCLES, 4: consecutive samples required to accept a new level; legal range 1..65535.
- RESET_VAL, 1'b0: value of level_out (and the assumed input level) after reset.
- GLITCH_W, 8: width of the glitch counter.

Ports:
- dst_clk  input  1  destination clock; single clock domain for the whole block.
- dst_rst_n  input  1  asynchronous active-low reset.
- sync_in  input  1  synchronised level from the upstream 2-FF synchroniser; treated as glitch-free per cycle but possibly bouncing.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse in the cycle level_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse in the cycle level_out goes 1->0.
- qualifying  output  1  high while a candidate level change is being timed.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- glitch_cnt  output  GLITCH_W  saturating count of aborted qualifications.

Behaviour:
- Reset (async assert, sync-to-dst_clk release is the integrator's job):
  - level_out=RESET_VAL; rise_pulse=0, fall_pulse=0, qualifying=0; glitch_cnt=0.
  - Internal counter = 0; state = STABLE.
- All outputs are registered; no combinational path from sync_in to any output.
- Counter width: $clog2(STABLE_CYCLES+1), minimum 1.
- FSM, two states:
  - STABLE, sync_in == level_out: hold; cnt=0.
  - STABLE, sync_in != level_out, STABLE_CYCLES==1: flip level_out at this edge; pulse rise/fall; stay STABLE.
  - STABLE, sync_in != level_out, STABLE_CYCLES>1: go QUAL; cnt<=1; qualifying<=1.
  - QUAL, sync_in == level_out (abort): go STABLE; cnt<=0; qualifying<=0; glitch_cnt += 1 (saturating).
  - QUAL, sync_in != level_out, cnt == STABLE_CYCLES-1: flip level_out; pulse rise/fall per new value; go STABLE; cnt<=0; qualifying<=0.
  - QUAL, otherwise: cnt += 1.
- Latency:
  - Suppose sync_in differs from level_out first at edge k and stays different.
  - level_out changes at edge k+STABLE_CYCLES-1, i.e. after exactly STABLE_CYCLES differing samples.
  - rise_pulse/fall_pulse are high for exactly the cycle following that edge, concurrent with the new level_out.
- Pulses: never both high; at most one pulse per level change.
- Back-to-back changes: the earliest re-qualification starts at the edge after the flip, so the minimum spacing between pulses is STABLE_CYCLES cycles.
- Glitch counter:
  - Saturates at all-ones and never wraps.
  - glitch_clr has priority over an increment in the same cycle (result 0, increment dropped).
  - Completed qualifications never increment it.
- Reset mid-qualification: everything returns to reset values immediately; no pulse emitted; the partial count is discarded.
- sync_in equal to RESET_VAL after reset: no activity.
- sync_in differing from RESET_VAL after reset: treated as a normal change, pulse emitted after STABLE_CYCLES samples.

Test Plan:
- Reset/idle (STABLE_CYCLES=4, RESET_VAL=0): hold dst_rst_n low, then release with sync_in=0 for 20 cycles -> level_out=0, no pulses, glitch_cnt=0, qualifying=0 throughout.
- Clean rise: sync_in 0->1 sampled first at edge k and held high -> qualifying=1 from k; level_out=1 and rise_pulse=1 for one cycle after edge k+3; glitch_cnt stays 0. Repeat 1->0 -> one fall_pulse after 4 samples.
- Glitch rejection: sync_in high for 3 samples, then low -> no pulse, level_out stays 0, glitch_cnt=1. Repeat 300 times with GLITCH_W=8 -> glitch_cnt saturates at 255.
- Clear vs increment collision: assert glitch_clr in the same cycle as an abort -> glitch_cnt=0 on the next cycle, not 1.
- STABLE_CYCLES=1: each sync_in change -> level_out follows at the sampling edge with one pulse; qualifying never asserts; glitch_cnt never increments.
- Reset mid-operation: sync_in goes high, assert dst_rst_n after 2 qualifying samples -> outputs return to reset values immediately. After release with sync_in still high, rise_pulse occurs exactly 4 samples after release, not earlier.
